// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for the execute stage.
// Radix-2 restoring division, one quotient bit per CALC cycle, with valid/ready on
// both the request and result sides.
// Optional feature macro: DIV_EARLY_OUT_EN (finish in one cycle when |dividend| < |divisor|).
module exe_div_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            req_v_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [4:0]      req_rd_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            res_v_o,
  input  logic            res_ready_i,
  output logic [4:0]      res_rd_o,
  output logic [XLEN-1:0] res_data_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            op_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            res_v_q;
  logic [4:0]      res_rd_q;
  logic [XLEN-1:0] res_data_q;

  // Accept-side decode: magnitudes, special cases and their immediate results
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            sgn_ovf;
  logic            early_out;
  logic            fast_path;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    is_signed = ~req_op_i[0];
    a_neg     = is_signed & rs1_data_i[XLEN-1];
    b_neg     = is_signed & rs2_data_i[XLEN-1];
    a_mag     = a_neg ? (~rs1_data_i + XLEN'(1)) : rs1_data_i;
    b_mag     = b_neg ? (~rs2_data_i + XLEN'(1)) : rs2_data_i;
    div_zero  = (rs2_data_i == '0);
    sgn_ovf   = is_signed & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early_out = ~div_zero & ~sgn_ovf & (a_mag < b_mag);
`else
    early_out = 1'b0;
`endif
    fast_path = div_zero | sgn_ovf | early_out;
    fast_res  = '0;
    if (div_zero) begin
      fast_res = req_op_i[1] ? rs1_data_i : '1;
    end else if (sgn_ovf) begin
      fast_res = req_op_i[1] ? '0 : rs1_data_i;
    end else if (early_out) begin
      fast_res = req_op_i[1] ? rs1_data_i : '0;
    end
  end

  // One restoring step plus the sign-corrected final values for the last step
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    ge      = (rem_sh >= {1'b0, dvs_q});
    diff    = rem_sh - {1'b0, dvs_q};
    rem_nx  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    quo_fix = neg_quo_q ? (~quo_nx + XLEN'(1)) : quo_nx;
    rem_fix = neg_rem_q ? (~rem_nx + XLEN'(1)) : rem_nx;
  end

  // Sequencer FSM with registered result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      op_rem_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_v_q    <= 1'b0;
      res_rd_q   <= '0;
      res_data_q <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      res_v_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_v_i) begin
            res_rd_q <= req_rd_i;
            if (fast_path) begin
              res_data_q <= fast_res;
              res_v_q    <= 1'b1;
              state      <= DONE;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_mag;
              dvs_q     <= b_mag;
              cnt       <= CW'(XLEN);
              op_rem_q  <= req_op_i[1];
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              state     <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_data_q <= op_rem_q ? rem_fix : quo_fix;
            res_v_q    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_v_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue-side handshake and status
  assign req_ready_o = (state == IDLE) & ~flush_i;
  assign busy_o      = (state != IDLE);
  assign res_v_o     = res_v_q;
  assign res_rd_o    = res_rd_q;
  assign res_data_o  = res_data_q;

endmodule
